iomem_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the SoC iomem bus (valid/ready/wstrb/addr/wdata/rdata, picorv32 iomem semantics).
- Lets the CPU iomem port (m0) and a second bus master (m1, e.g. DMA or debug bridge) share the board-level peripheral decoder, which sits in the slave position.
- Arbitration is round-robin. A bus watchdog completes stalled transfers with an error word so that a missing peripheral can never hang either master.

---
 rtl/iomem_arbiter_pkg.sv | 19 +
 rtl/iomem_rr_pick.sv | 26 ++
 rtl/iomem_arbiter.sv | 157 +++++++++++++++
 tb/tb_iomem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_arbiter_pkg.sv
// Shared definitions for the iomem two-master arbiter.
//   state_t           : arbiter FSM encoding (IDLE/BUSY/ABORT)
//   M0 / M1           : master identifiers used for grant and error reporting
//   ERR_RDATA_DEF     : read data returned on an aborted or unmapped access;
//                       also used by the peripheral decoder for unmapped addresses
package iomem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [31:0] ERR_RDATA_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/iomem_rr_pick.sv
// Combinational 2-way round-robin picker.
//   i_req[1:0] : request vector, bit n = master n
//   i_last     : id of the master that completed the previous transfer
//   o_gnt      : master to grant (only meaningful when o_any is high)
//   o_any      : at least one request pending
module iomem_rr_pick
    import iomem_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_gnt,
    output logic       o_any
);

    always_comb begin
        o_any = |i_req;
        case (i_req)
            2'b01:   o_gnt = M0;
            2'b10:   o_gnt = M1;
            // Both pending: whoever was not served last goes next.
            2'b11:   o_gnt = ~i_last;
            default: o_gnt = M0;
        endcase
    end

endmodule

// File: rtl/iomem_arbiter.sv
// Two-master / one-slave arbiter for the picorv32-style iomem bus.
// Round-robin arbitration with a bus watchdog that completes stalled
// transfers with an error word so a missing peripheral cannot hang a master.
//   clk, resetn                         : clock, asynchronous active-low reset
//   m0_* / m1_*                         : master ports (valid/ready/wstrb/addr/wdata/rdata)
//   s_*                                 : slave port towards the peripheral decoder
//   err_flag / err_master / err_clear   : sticky abort flag, id of aborted master, clear
// Parameters:
//   TIMEOUT   : BUSY cycles without s_ready before abort (0 disables the watchdog)
//   ERR_RDATA : read data returned on an aborted transfer
module iomem_arbiter
    import iomem_arbiter_pkg::*;
#(
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    input  logic        s_ready,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,

    output logic        err_flag,
    output logic        err_master,
    input  logic        err_clear
);

    // A zero-width counter is not legal, so keep at least one bit when the
    // watchdog is disabled.
    localparam int TCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TCNT_W-1:0] TLAST = (TIMEOUT > 0) ? TCNT_W'(TIMEOUT - 1) : '0;

    state_t            r_state;
    logic              r_gnt;
    logic              r_last;
    logic [TCNT_W-1:0] r_tcnt;
    logic              r_err_flag;
    logic              r_err_master;

    logic              w_pick;
    logic              w_any;
    logic              w_done;
    logic [31:0]       w_rdata;

    iomem_rr_pick u_pick (
        .i_req  ({m1_valid, m0_valid}),
        .i_last (r_last),
        .o_gnt  (w_pick),
        .o_any  (w_any)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_gnt        <= M0;
            r_last       <= M1;          // so m0 wins the first contention
            r_tcnt       <= '0;
            r_err_flag   <= 1'b0;
            r_err_master <= M0;
        end else begin
            // Clear first so an abort in the same cycle overrides it.
            if (err_clear) begin
                r_err_flag <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_pick;
                        r_tcnt  <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (s_ready) begin
                        r_last  <= r_gnt;
                        r_state <= IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                        if (TIMEOUT != 0 && r_tcnt == TLAST) begin
                            r_state <= ABORT;
                        end
                    end
                end
                ABORT: begin
                    r_err_flag   <= 1'b1;
                    r_err_master <= r_gnt;
                    r_last       <= r_gnt;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Slave request and master completion are combinational so a 1-cycle
    // slave finishes in the same cycle it is addressed. The slave-side
    // address/data are zeroed outside BUSY so nothing leaks from an
    // ungranted master.
    always_comb begin
        s_valid  = 1'b0;
        s_wstrb  = '0;
        s_addr   = '0;
        s_wdata  = '0;
        m0_ready = 1'b0;
        m0_rdata = '0;
        m1_ready = 1'b0;
        m1_rdata = '0;
        w_done   = 1'b0;
        w_rdata  = '0;
        case (r_state)
            BUSY: begin
                s_valid = 1'b1;
                s_wstrb = (r_gnt == M1) ? m1_wstrb : m0_wstrb;
                s_addr  = (r_gnt == M1) ? m1_addr  : m0_addr;
                s_wdata = (r_gnt == M1) ? m1_wdata : m0_wdata;
                w_done  = s_ready;
                w_rdata = s_rdata;
            end
            ABORT: begin
                w_done  = 1'b1;
                w_rdata = ERR_RDATA;
            end
            default: ;
        endcase
        if (w_done) begin
            if (r_gnt == M1) begin
                m1_ready = 1'b1;
                m1_rdata = w_rdata;
            end else begin
                m0_ready = 1'b1;
                m0_rdata = w_rdata;
            end
        end
    end

    assign err_flag   = r_err_flag;
    assign err_master = r_err_master;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Bench for iomem_arbiter: two instances share all inputs, one with an
// 8-cycle watchdog (dut_a) and one with the watchdog disabled (dut_b).
// A transaction-level model predicts every output of both every cycle;
// directed checks pin specific expected values.
module tb_iomem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m1_valid, s_ready, err_clear;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;

    logic        a_m0_ready, a_m1_ready, a_s_valid, a_err_flag, a_err_master;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
    logic [3:0]  a_s_wstrb;
    logic        b_m0_ready, b_m1_ready, b_s_valid, b_err_flag, b_err_master;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
    logic [3:0]  b_s_wstrb;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    iomem_arbiter #(.TIMEOUT(8)) dut_a (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(a_m0_ready), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(a_m0_rdata),
        .m1_valid(m1_valid), .m1_ready(a_m1_ready), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(a_m1_rdata),
        .s_valid(a_s_valid), .s_ready(s_ready), .s_wstrb(a_s_wstrb),
        .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_rdata(s_rdata),
        .err_flag(a_err_flag), .err_master(a_err_master), .err_clear(err_clear)
    );

    iomem_arbiter #(.TIMEOUT(0)) dut_b (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(b_m0_ready), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(b_m0_rdata),
        .m1_valid(m1_valid), .m1_ready(b_m1_ready), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(b_m1_rdata),
        .s_valid(b_s_valid), .s_ready(s_ready), .s_wstrb(b_s_wstrb),
        .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_rdata(s_rdata),
        .err_flag(b_err_flag), .err_master(b_err_master), .err_clear(err_clear)
    );

    // Observed outputs, packed:
    // {s_valid, s_wstrb, s_addr, s_wdata, m0_ready, m0_rdata, m1_ready, m1_rdata, err_flag, err_master}
    logic [136:0] a_obs, b_obs;
    assign a_obs = {a_s_valid, a_s_wstrb, a_s_addr, a_s_wdata, a_m0_ready, a_m0_rdata,
                    a_m1_ready, a_m1_rdata, a_err_flag, a_err_master};
    assign b_obs = {b_s_valid, b_s_wstrb, b_s_addr, b_s_wdata, b_m0_ready, b_m0_rdata,
                    b_m1_ready, b_m1_rdata, b_err_flag, b_err_master};

    // Transaction model: owner is the master whose transfer is in flight
    // (-1 = none), waited counts stalled cycles, abt marks the error-completion cycle.
    int m_tmo[2]   = '{8, 0};
    int m_owner[2] = '{-1, -1};
    int m_wait[2]  = '{0, 0};
    bit m_abt[2]   = '{0, 0};
    bit m_last[2]  = '{1, 1};
    bit m_err[2]   = '{0, 0};
    bit m_errm[2]  = '{0, 0};

    task automatic step(int i);
        if (err_clear) m_err[i] = 1'b0;
        if (m_abt[i]) begin
            m_err[i]   = 1'b1;
            m_errm[i]  = (m_owner[i] == 1);
            m_last[i]  = (m_owner[i] == 1);
            m_owner[i] = -1;
            m_abt[i]   = 1'b0;
        end else if (m_owner[i] >= 0) begin
            if (s_ready) begin
                m_last[i]  = (m_owner[i] == 1);
                m_owner[i] = -1;
            end else begin
                m_wait[i] = m_wait[i] + 1;
                if (m_tmo[i] > 0 && m_wait[i] == m_tmo[i]) m_abt[i] = 1'b1;
            end
        end else if (m0_valid || m1_valid) begin
            if (m0_valid && m1_valid) m_owner[i] = m_last[i] ? 0 : 1;
            else                      m_owner[i] = m1_valid ? 1 : 0;
            m_wait[i] = 0;
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                m_owner[i] = -1; m_wait[i] = 0; m_abt[i] = 1'b0;
                m_last[i]  = 1'b1; m_err[i] = 1'b0; m_errm[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) step(i);
        end
    end

    function automatic logic [136:0] expect_out(int i);
        bit          sv, done;
        int          o;
        logic [31:0] rd;
        o    = m_owner[i];
        sv   = (o >= 0) && !m_abt[i];
        done = (sv && s_ready) || m_abt[i];
        rd   = m_abt[i] ? 32'hFFFF_FFFF : s_rdata;
        return {sv,
                sv ? ((o == 1) ? m1_wstrb : m0_wstrb) : 4'h0,
                sv ? ((o == 1) ? m1_addr  : m0_addr)  : 32'h0,
                sv ? ((o == 1) ? m1_wdata : m0_wdata) : 32'h0,
                done && (o == 0), (done && (o == 0)) ? rd : 32'h0,
                done && (o == 1), (done && (o == 1)) ? rd : 32'h0,
                m_err[i], m_errm[i]};
    endfunction

    task automatic cmp_model(int i, logic [136:0] obs);
        logic [136:0] exp_v, got;
        exp_v = expect_out(i);
        got   = obs;
        // Slave address/data are only meaningful while a request is presented.
        if (!exp_v[136]) got[135:68] = '0;
        n_cmp++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL model_dut%0d t=%0t got %h want %h", i, $time, got, exp_v);
        end
    endtask

    always @(negedge clk) begin
        cmp_model(0, a_obs);
        cmp_model(1, b_obs);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; m0_valid = 0; m1_valid = 0; s_ready = 0; err_clear = 0;
        m0_wstrb = 0; m1_wstrb = 0; m0_addr = 0; m0_wdata = 0;
        m1_addr = 0; m1_wdata = 0; s_rdata = 0;

        // Reset state
        @(negedge clk);
        chk("rst_s_valid", a_s_valid, 0);
        chk("rst_err_flag", a_err_flag, 0);
        chk("rst_err_master", b_err_master, 0);
        chk("rst_m0_ready", a_m0_ready, 0);

        // Single read by m0 with a 1-cycle slave
        tick();
        resetn = 1'b1;
        m0_valid = 1; m0_addr = 32'h0300_0000; m0_wstrb = 4'h0;
        @(negedge clk);
        chk("rd_arb_cycle_s_valid", a_s_valid, 0);
        tick();
        s_ready = 1; s_rdata = 32'h0000_00A5;
        @(negedge clk);
        chk("rd_s_valid", a_s_valid, 1);
        chk("rd_s_addr", a_s_addr, 32'h0300_0000);
        chk("rd_m0_ready", a_m0_ready, 1);
        chk("rd_m0_rdata", a_m0_rdata, 32'h0000_00A5);
        chk("rd_m1_ready", a_m1_ready, 0);
        tick();
        m0_valid = 0; s_ready = 0; s_rdata = 0;
        @(negedge clk);
        chk("rd_m0_ready_pulse", a_m0_ready, 0);

        // Contention after reset: m0, m1, m0, m1 with an IDLE cycle between
        tick();
        resetn = 1'b0;
        m0_valid = 1; m0_addr = 32'h0300_0004; m0_wdata = 32'hDEAD_0000; m0_wstrb = 4'h0;
        m1_valid = 1; m1_addr = 32'h0300_0008; m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF;
        s_ready = 1; s_rdata = 32'h0000_0011;
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bit odd;
            bit g;
            @(negedge clk);
            odd = (k % 2) == 1;
            g   = ((k / 2) % 2) == 1;
            chk($sformatf("cont%0d_s_valid", k), a_s_valid, odd);
            chk($sformatf("cont%0d_m0_ready", k), a_m0_ready, odd && !g);
            chk($sformatf("cont%0d_m1_ready", k), a_m1_ready, odd && g);
            chk($sformatf("cont%0d_s_wdata", k), a_s_wdata,
                !odd ? 32'h0 : (g ? 32'h1234_5678 : 32'hDEAD_0000));
            chk($sformatf("cont%0d_s_wstrb", k), a_s_wstrb, (odd && g) ? 4'hF : 4'h0);
        end

        // Watchdog: m1 reads a dead address, slave never answers
        tick();
        m0_valid = 0; m0_wdata = 0;
        s_ready = 0; s_rdata = 0;
        m1_valid = 1; m1_addr = 32'h0700_0000; m1_wstrb = 4'h0; m1_wdata = 0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("wd_busy%0d_s_valid", k), a_s_valid, 1);
            chk($sformatf("wd_busy%0d_m1_ready", k), a_m1_ready, 0);
        end
        @(negedge clk);
        chk("wd_abort_s_valid", a_s_valid, 0);
        chk("wd_abort_m1_ready", a_m1_ready, 1);
        chk("wd_abort_m1_rdata", a_m1_rdata, 32'hFFFF_FFFF);
        chk("wd_abort_m0_ready", a_m0_ready, 0);
        tick();
        m1_valid = 0;
        @(negedge clk);
        chk("wd_err_flag", a_err_flag, 1);
        chk("wd_err_master", a_err_master, 1);
        chk("wd_m1_ready_pulse", a_m1_ready, 0);
        tick();
        tick();
        s_ready = 1;
        @(negedge clk);
        chk("late_ready_m1_ready", a_m1_ready, 0);
        chk("late_ready_s_valid", a_s_valid, 0);
        chk("nowd_late_ready_completes", b_m1_ready, 1);
        tick();
        s_ready = 0;

        // Second abort (m0) with err_clear in the same cycle, then a lone clear
        m0_valid = 1; m0_addr = 32'h0700_0010; m0_wstrb = 4'h0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) @(negedge clk);
        chk("abort2_last_busy_s_valid", a_s_valid, 1);
        tick();
        err_clear = 1;
        @(negedge clk);
        chk("abort2_m0_ready", a_m0_ready, 1);
        chk("abort2_m0_rdata", a_m0_rdata, 32'hFFFF_FFFF);
        tick();
        err_clear = 0; m0_valid = 0;
        @(negedge clk);
        chk("set_wins_err_flag", a_err_flag, 1);
        chk("abort2_err_master", a_err_master, 0);
        tick();
        err_clear = 1;
        tick();
        err_clear = 0;
        @(negedge clk);
        chk("clear_err_flag", a_err_flag, 0);

        // Reset in the middle of a transfer
        m1_valid = 1; m1_addr = 32'h0700_0020;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_s_valid", a_s_valid, 1);
        #1;
        resetn = 1'b0;
        #1;
        chk("async_rst_a_s_valid", a_s_valid, 0);
        chk("async_rst_b_s_valid", b_s_valid, 0);
        m0_valid = 1; m0_addr = 32'h0300_0040;
        s_ready = 1; s_rdata = 32'h0000_0077;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_idle_s_valid", a_s_valid, 0);
        @(negedge clk);
        chk("post_rst_s_addr", a_s_addr, 32'h0300_0040);
        chk("post_rst_m0_ready", a_m0_ready, 1);
        chk("post_rst_m0_rdata", a_m0_rdata, 32'h0000_0077);
        chk("post_rst_m1_ready", a_m1_ready, 0);
        tick();
        m0_valid = 0; m1_valid = 0; s_ready = 0; s_rdata = 0;

        // Watchdog disabled: 1000-cycle stall completes normally on dut_b
        tick();
        m0_valid = 1; m0_addr = 32'h0300_0080; s_rdata = 32'h5A5A_0001;
        repeat (1000) @(posedge clk);
        #1;
        s_ready = 1;
        @(negedge clk);
        chk("nowd_s_valid", b_s_valid, 1);
        chk("nowd_m0_ready", b_m0_ready, 1);
        chk("nowd_m0_rdata", b_m0_rdata, 32'h5A5A_0001);
        chk("nowd_err_flag", b_err_flag, 0);
        tick();
        m0_valid = 0; s_ready = 0; s_rdata = 0;
        @(negedge clk);
        chk("nowd_done_s_valid", b_s_valid, 0);
        chk("nowd_done_err_flag", b_err_flag, 0);
        chk("nowd_done_m0_ready", b_m0_ready, 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
